// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, opcodes and default width for the ALU sequencer
package alu_seq_pkg;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, DRIVE, RESP} state_t;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_INVALID = 3'd7;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: requester handshakes, response and ALU latch/bus signals of the sequencer
interface alu_seq_if #(parameter int DATA_W = 16);
  logic req0_valid, req0_ready;
  logic [2:0] req0_op;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic req1_valid, req1_ready;
  logic [2:0] req1_op;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic rsp_valid, rsp_id, rsp_err, busy;
  logic [DATA_W-1:0] rsp_result;
  logic [DATA_W-1:0] ALU_In1, ALU_In2, BUS_In;
  logic [2:0] ALU_Sel;
  logic ALU_In1_En, ALU_In2_En, ALU_Out_En, BUS_Tri_En;
  modport master (
    input req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, BUS_In,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_result, busy,
    output ALU_In1, ALU_In2, ALU_Sel, ALU_In1_En, ALU_In2_En, ALU_Out_En, BUS_Tri_En
  );
  modport slave (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b, BUS_In,
    input req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_result, busy,
    input ALU_In1, ALU_In2, ALU_Sel, ALU_In1_En, ALU_In2_En, ALU_Out_En, BUS_Tri_En
  );
endinterface

// File: rtl/alu_seq_arb.sv
// alu_seq_arb: two-way grant; round-robin when ALU_SEQ_RR_EN is defined, else requester 0 wins
module alu_seq_arb (
  input  logic clk,
  input  logic rst,
  input  logic v0,
  input  logic v1,
  input  logic take,
  output logic gnt_valid,
  output logic gnt_id
);
  assign gnt_valid = v0 || v1;
`ifdef ALU_SEQ_RR_EN
  logic ptr;
  always_ff @(posedge clk)
    if (rst) ptr <= 1'b0;
    else if (take) ptr <= ~gnt_id;
  assign gnt_id = (v0 && v1) ? ptr : v1;
`else
  logic unused;
  assign unused = ^{clk, rst, take};
  assign gnt_id = v1 && !v0;
`endif
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: shares one ALU between two requesters, stepping LOAD/EXEC/DRIVE/RESP
// Arbitration mode selected by ALU_SEQ_RR_EN (see alu_seq_arb).
module alu_sequencer import alu_seq_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int EXEC_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  alu_seq_if.master io
);
  state_t state, next;
  logic [3:0] cnt;
  logic gnt_valid, gnt_id, hs;
  logic [2:0] op;
  logic [DATA_W-1:0] a, b;
  alu_seq_arb arb (.clk, .rst, .v0(io.req0_valid), .v1(io.req1_valid), .take(hs), .gnt_valid, .gnt_id);
  assign hs = state == IDLE && gnt_valid;
  assign io.req0_ready = hs && !gnt_id;
  assign io.req1_ready = hs && gnt_id;
  assign op = gnt_id ? io.req1_op : io.req0_op;
  assign a = gnt_id ? io.req1_a : io.req0_a;
  assign b = gnt_id ? io.req1_b : io.req0_b;
  assign io.ALU_In1_En = state == LOAD;
  assign io.ALU_In2_En = state == LOAD;
  assign io.ALU_Out_En = state == EXEC;
  assign io.BUS_Tri_En = state == DRIVE;
  assign io.rsp_valid = state == RESP;
  assign io.busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = hs ? (op == OP_INVALID ? RESP : LOAD) : IDLE;
      LOAD:    next = EXEC;
      EXEC:    next = cnt == '0 ? DRIVE : EXEC;
      DRIVE:   next = RESP;
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  // Operand/select registers double as the held ALU inputs; an invalid op leaves them untouched.
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      io.ALU_In1 <= '0;
      io.ALU_In2 <= '0;
      io.ALU_Sel <= '0;
      io.rsp_result <= '0;
      io.rsp_id <= 1'b0;
      io.rsp_err <= 1'b0;
    end else begin
      if (hs) begin
        io.rsp_id <= gnt_id;
        io.rsp_err <= op == OP_INVALID;
        if (op == OP_INVALID) io.rsp_result <= '0;
        else begin
          io.ALU_In1 <= a;
          io.ALU_In2 <= b;
          io.ALU_Sel <= op;
        end
      end
      if (state == LOAD) cnt <= 4'(EXEC_CYCLES - 1);
      else if (state == EXEC && cnt != '0) cnt <= cnt - 4'd1;
      if (state == DRIVE) io.rsp_result <= io.BUS_In;
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed scoreboard bench with a behavioural ALU on the shared bus
module tb_alu_sequencer;
  import alu_seq_pkg::*;
  localparam int W = 16;
  typedef struct {logic id; logic [W-1:0] res; logic err; int hs;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  alu_seq_if #(.DATA_W(W)) b();
  alu_seq_if #(.DATA_W(W)) c();
  alu_sequencer #(.DATA_W(W), .EXEC_CYCLES(1)) dut (.clk(clk), .rst(rst), .io(b));
  alu_sequencer #(.DATA_W(W), .EXEC_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .io(c));
  int tests = 0, fails = 0, cyc = 0;
  exp_t sb[$];
  exp_t e;
  int hs_log[$];
  logic gnt_log[$];
  logic [W-1:0] res_log[$];
  logic last_err;
  int n_ld1 = 0, n_ld2 = 0, n_ex = 0, n_dr = 0, ld_at = 0, dr_at = 0;
  logic [W-1:0] m1, m2, mo, k1, k2, ko;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [W-1:0] alu_f(logic [2:0] op, logic [W-1:0] x, logic [W-1:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      default: return '0;
    endcase
  endfunction
  always @(posedge clk) begin
    if (b.ALU_In1_En) m1 <= b.ALU_In1;
    if (b.ALU_In2_En) m2 <= b.ALU_In2;
    if (b.ALU_Out_En) mo <= alu_f(b.ALU_Sel, m1, m2);
    if (c.ALU_In1_En) k1 <= c.ALU_In1;
    if (c.ALU_In2_En) k2 <= c.ALU_In2;
    if (c.ALU_Out_En) ko <= alu_f(c.ALU_Sel, k1, k2);
  end
  assign b.BUS_In = b.BUS_Tri_En ? mo : 16'hDEAD;
  assign c.BUS_In = c.BUS_Tri_En ? ko : 16'hDEAD;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (b.req0_valid && b.req0_ready) begin
        sb.push_back('{id: 1'b0, res: alu_f(b.req0_op, b.req0_a, b.req0_b), err: b.req0_op == OP_INVALID, hs: cyc});
        hs_log.push_back(cyc);
        gnt_log.push_back(1'b0);
      end
      if (b.req1_valid && b.req1_ready) begin
        sb.push_back('{id: 1'b1, res: alu_f(b.req1_op, b.req1_a, b.req1_b), err: b.req1_op == OP_INVALID, hs: cyc});
        hs_log.push_back(cyc);
        gnt_log.push_back(1'b1);
      end
      if (b.busy && (b.req0_ready || b.req1_ready)) check("ready_while_busy", 1, 0);
      if (b.ALU_In1_En) begin n_ld1++; ld_at = cyc; end
      if (b.ALU_In2_En) n_ld2++;
      if (b.ALU_Out_En) n_ex++;
      if (b.BUS_Tri_En) begin n_dr++; dr_at = cyc; end
      if (b.rsp_valid) begin
        if (sb.size() == 0) check("spurious_rsp", 1, 0);
        else begin
          e = sb.pop_front();
          check("rsp_id", b.rsp_id, e.id);
          check("rsp_result", b.rsp_result, e.res);
          check("rsp_err", b.rsp_err, e.err);
          check("latency", cyc - e.hs, e.err ? 1 : 4);
          res_log.push_back(b.rsp_result);
          last_err = b.rsp_err;
        end
      end
    end
  end
  task automatic send(input logic id, input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    if (id) begin b.req1_op = op; b.req1_a = x; b.req1_b = y; b.req1_valid = 1'b1; end
    else begin b.req0_op = op; b.req0_a = x; b.req0_b = y; b.req0_valid = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (id ? b.req1_ready : b.req0_ready) begin
        @(posedge clk); #1;
        if (id) b.req1_valid = 1'b0; else b.req0_valid = 1'b0;
        return;
      end
    end
    check("handshake_timeout", 1, 0);
    b.req0_valid = 1'b0;
    b.req1_valid = 1'b0;
  endtask
  task automatic wait_rsp();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) return;
      @(posedge clk); #1;
    end
    check("rsp_timeout", 1, 0);
  endtask
  int bl1, bl2, bx, bd, base, h, oe, tr, lat;
  logic [W-1:0] r3;
  initial begin
    {b.req0_valid, b.req1_valid, c.req0_valid, c.req1_valid} = '0;
    {b.req0_op, b.req1_op, c.req0_op, c.req1_op} = '0;
    {b.req0_a, b.req0_b, b.req1_a, b.req1_b} = '0;
    {c.req0_a, c.req0_b, c.req1_a, c.req1_b} = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_enables", {b.ALU_In1_En, b.ALU_In2_En, b.ALU_Out_En, b.BUS_Tri_En}, 0);
    check("reset_busy", b.busy, 0);
    check("reset_rsp", {b.rsp_valid, b.rsp_id, b.rsp_err, b.rsp_result}, 0);
    check("reset_operands", {b.ALU_In1, b.ALU_In2, b.ALU_Sel}, 0);
    rst = 1'b0;
    {bl1, bl2, bx, bd} = {n_ld1, n_ld2, n_ex, n_dr};
    send(1'b0, OP_ADD, 16'h004C, 16'h002A);
    wait_rsp();
    check("add_result", res_log[$], 16'h0076);
    check("add_in_en_pulses", {16'(n_ld1 - bl1), 16'(n_ld2 - bl2)}, {16'd1, 16'd1});
    check("add_out_en_pulses", n_ex - bx, 1);
    check("add_tri_pulses", n_dr - bd, 1);
    check("load_cycle", ld_at - hs_log[$], 1);
    check("drive_cycle", dr_at - hs_log[$], 3);
    send(1'b1, OP_SUB, 16'h004C, 16'h002A);
    send(1'b1, OP_AND, 16'h004C, 16'h002A);
    wait_rsp();
    check("sub_result", res_log[$-1], 16'h0022);
    check("and_result", res_log[$], 16'h0008);
    check("b2b_gap", hs_log[$] - hs_log[$-1], 5);
    {bl1, bl2, bx, bd} = {n_ld1, n_ld2, n_ex, n_dr};
    send(1'b0, OP_INVALID, 16'h1111, 16'h2222);
    wait_rsp();
    check("inv_err", last_err, 1);
    check("inv_result", res_log[$], 0);
    check("inv_no_enables", (n_ld1 - bl1) + (n_ld2 - bl2) + (n_ex - bx) + (n_dr - bd), 0);
    send(1'b0, OP_ADD, 16'h0001, 16'h0002);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b.ALU_Out_En) break;
    end
    check("reached_exec", b.ALU_Out_En, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_enables", {b.ALU_In1_En, b.ALU_In2_En, b.ALU_Out_En, b.BUS_Tri_En}, 0);
    check("mid_rst_busy", b.busy, 0);
    check("mid_rst_rsp", {b.rsp_valid, b.rsp_result}, 0);
    check("mid_rst_operands", {b.ALU_In1, b.ALU_Sel}, 0);
    sb.delete();
    rst = 1'b0;
    base = res_log.size();
    repeat (6) @(negedge clk);
    check("no_rsp_after_rst", res_log.size() - base, 0);
    send(1'b1, OP_ADD, 16'h0100, 16'h0023);
    wait_rsp();
    check("post_rst_result", res_log[$], 16'h0123);
    b.req0_op = OP_ADD; b.req0_a = 16'h0001; b.req0_b = 16'h0001;
    b.req1_op = OP_SUB; b.req1_a = 16'h0009; b.req1_b = 16'h0002;
    b.req0_valid = 1'b1;
    b.req1_valid = 1'b1;
    base = gnt_log.size();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (gnt_log.size() >= base + 4) break;
    end
    b.req0_valid = 1'b0;
    b.req1_valid = 1'b0;
    wait_rsp();
    check("arb_grants", gnt_log.size() - base, 4);
    for (int i = 0; i < 4; i++)
`ifdef ALU_SEQ_RR_EN
      check($sformatf("arb_grant%0d", i), (base + i < gnt_log.size()) ? gnt_log[base + i] : 1'bx, 1'(i % 2));
`else
      check($sformatf("arb_grant%0d", i), (base + i < gnt_log.size()) ? gnt_log[base + i] : 1'bx, 1'b0);
`endif
    c.req0_op = OP_ADD; c.req0_a = 16'h1234; c.req0_b = 16'h0101;
    c.req0_valid = 1'b1;
    h = -100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (c.req0_ready) begin h = cyc; break; end
    end
    @(posedge clk); #1;
    c.req0_valid = 1'b0;
    {oe, tr, lat} = {32'd0, 32'd0, -32'sd1};
    r3 = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (c.ALU_Out_En) oe++;
      if (c.BUS_Tri_En) tr++;
      if (c.rsp_valid) begin lat = cyc - h; r3 = c.rsp_result; break; end
    end
    check("x3_out_en_cycles", oe, 3);
    check("x3_tri_cycles", tr, 1);
    check("x3_latency", lat, 6);
    check("x3_result", r3, 16'h1335);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
